switch_scan_ctrl: RTL and testbench

//  Clocked controller between the 8 DIP switches and the LED / 2x 7-seg outputs.

---
 rtl/switch_scan_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_switch_scan_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/switch_scan_ctrl.sv
// switch_scan_ctrl: debounces the 8 DIP switches, mirrors them on the LEDs and
// walks the two-digit 7-seg display through S<n> for every switch that is ON.
// The display shows SA when all switches are ON and stays blank when none are.
// data_0/data_1 are hexdigit codes: 0-15 hex, 19 = 'S', 20 = blank.
module switch_scan_ctrl #(
  parameter int DEB_CYCLES   = 500000,
  parameter int DWELL_CYCLES = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] prswi,
  output logic [7:0] prled,
  output logic [4:0] data_0,
  output logic [4:0] data_1,
  output logic       dp,
  output logic       sw_chg
);

  localparam int DEB_W = $clog2(DEB_CYCLES);
  localparam int DWELL_W = $clog2(DWELL_CYCLES);
  localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEB_CYCLES - 1);
  localparam logic [DWELL_W-1:0] DWELL_MAX = DWELL_W'(DWELL_CYCLES - 1);

  localparam logic [4:0] CODE_BLANK = 5'd20;
  localparam logic [4:0] CODE_S     = 5'd19;
  localparam logic [4:0] CODE_A     = 5'd10;

  typedef enum logic [1:0] {
    ST_BLANK,
    ST_ALL,
    ST_SEEK,
    ST_SHOW
  } state_t;

  // Synchroniser, debounce counter and debounced switch image
  logic [7:0]       s1_q, s1_d;
  logic [7:0]       s2_q, s2_d;
  logic [7:0]       s3_q, s3_d;
  logic [DEB_W-1:0] cnt_q, cnt_d;
  logic [7:0]       prled_q, prled_d;
  logic             sw_chg_q, sw_chg_d;

  // Display sequencer state
  state_t             state_q, state_d;
  logic [2:0]         idx_q, idx_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [4:0]         data0_q, data0_d;
  logic [4:0]         data1_q, data1_d;
  logic               dp_q, dp_d;

  logic               stable;
  logic [3:0]         ones;
  logic               multi_on;

  // Three-stage synchroniser feeding a saturating stability counter; the LED
  // image only moves once s2 has matched s3 for DEB_CYCLES consecutive cycles.
  always_comb begin
    s1_d     = prswi;
    s2_d     = s1_q;
    s3_d     = s2_q;
    stable   = (s2_q == s3_q);
    cnt_d    = cnt_q;
    prled_d  = prled_q;
    sw_chg_d = 1'b0;
    if (!stable) begin
      cnt_d = '0;
    end else if (cnt_q != DEB_MAX) begin
      cnt_d = cnt_q + DEB_W'(1);
    end
    if (stable && (cnt_q == DEB_MAX) && (s2_q != prled_q)) begin
      prled_d  = s2_q;
      sw_chg_d = 1'b1;
    end
  end

  // Number of ON switches in the debounced image, used for the decimal point
  always_comb begin
    ones = '0;
    for (int i = 0; i < 8; i++) begin
      ones = ones + {3'b000, prled_q[i]};
    end
    multi_on = (ones >= 4'd2);
  end

  // Next-state and display logic; a fresh debounced value overrides whatever
  // the sequencer was doing, including an expiring dwell.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    dwell_d = dwell_q;
    data0_d = data0_q;
    data1_d = data1_q;
    if (sw_chg_q) begin
      if (prled_q == 8'h00) begin
        state_d = ST_BLANK;
        data0_d = CODE_BLANK;
        data1_d = CODE_BLANK;
      end else if (prled_q == 8'hFF) begin
        state_d = ST_ALL;
        data0_d = CODE_A;
        data1_d = CODE_S;
      end else begin
        state_d = ST_SEEK;
        idx_d   = 3'd0;
      end
    end else begin
      case (state_q)
        ST_BLANK: begin
          data0_d = CODE_BLANK;
          data1_d = CODE_BLANK;
        end
        ST_ALL: begin
          data0_d = CODE_A;
          data1_d = CODE_S;
        end
        ST_SEEK: begin
          if (prled_q[idx_q]) begin
            data0_d = {2'b00, idx_q};
            data1_d = CODE_S;
            dwell_d = '0;
            state_d = ST_SHOW;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
        ST_SHOW: begin
          if (dwell_q == DWELL_MAX) begin
            idx_d   = idx_q + 3'd1;
            state_d = ST_SEEK;
          end else begin
            dwell_d = dwell_q + DWELL_W'(1);
          end
        end
        default: begin
          state_d = ST_BLANK;
          data0_d = CODE_BLANK;
          data1_d = CODE_BLANK;
        end
      endcase
    end
    dp_d = ((state_d == ST_SEEK) || (state_d == ST_SHOW)) && multi_on;
  end

  // Debounce registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q     <= '0;
      s2_q     <= '0;
      s3_q     <= '0;
      cnt_q    <= '0;
      prled_q  <= '0;
      sw_chg_q <= 1'b0;
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      s3_q     <= s3_d;
      cnt_q    <= cnt_d;
      prled_q  <= prled_d;
      sw_chg_q <= sw_chg_d;
    end
  end

  // Sequencer state and registered display outputs with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_BLANK;
      idx_q   <= '0;
      dwell_q <= '0;
      data0_q <= CODE_BLANK;
      data1_q <= CODE_BLANK;
      dp_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      dwell_q <= dwell_d;
      data0_q <= data0_d;
      data1_q <= data1_d;
      dp_q    <= dp_d;
    end
  end

  assign prled  = prled_q;
  assign data_0 = data0_q;
  assign data_1 = data1_q;
  assign dp     = dp_q;
  assign sw_chg = sw_chg_q;

endmodule

// File: tb/tb_switch_scan_ctrl.sv
// tb_switch_scan_ctrl: directed stimulus with a scoreboard of expected output
// changes; a monitor pops an entry each time the visible outputs change.
module tb_switch_scan_ctrl;

  logic       clk;
  logic       rst;
  logic [7:0] prswi;
  logic [7:0] prled;
  logic [4:0] data_0;
  logic [4:0] data_1;
  logic       dp;
  logic       sw_chg;

  int checks = 0;
  int errors = 0;
  logic mon_en = 1'b0;

  typedef struct {
    logic [7:0] prled;
    logic [4:0] d0;
    logic [4:0] d1;
    logic       dp;
    logic       chg;
    int         gap;
  } exp_t;

  exp_t sb[$];

  switch_scan_ctrl #(
    .DEB_CYCLES  (4),
    .DWELL_CYCLES(8)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .prswi (prswi),
    .prled (prled),
    .data_0(data_0),
    .data_1(data_1),
    .dp    (dp),
    .sw_chg(sw_chg)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Absolute time limit so the run always ends
  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] sw);
    prswi = sw;
  endtask

  task automatic pushExp(input logic [7:0] p, input logic [4:0] a, input logic [4:0] b,
                         input logic d, input logic c, input int g);
    exp_t e;
    e.prled = p;
    e.d0    = a;
    e.d1    = b;
    e.dp    = d;
    e.chg   = c;
    e.gap   = g;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic waitDrain(input int budget, input string tag);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL %s_timeout actual=%0d_pending required=0_pending", tag, sb.size());
      sb.delete();
    end
  endtask

  // Monitor: every change of the visible outputs (or any sw_chg pulse) must
  // match the next scoreboard entry; gap is cycles since the previous change.
  initial begin
    logic [20:0] prev;
    logic [20:0] cur;
    int          gap_cnt;
    exp_t        e;
    prev    = '0;
    gap_cnt = 0;
    forever begin
      @(negedge clk);
      cur = {prled, data_0, data_1, dp, 2'b00};
      if (!mon_en) begin
        prev    = cur;
        gap_cnt = 0;
      end else begin
        gap_cnt++;
        if ((cur !== prev) || (sw_chg !== 1'b0)) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_event actual=prled:%h d0:%0d d1:%0d dp:%0b chg:%0b required=no_change",
                     prled, data_0, data_1, dp, sw_chg);
          end else begin
            e = sb.pop_front();
            checkOutput("prled", 32'(prled), 32'(e.prled));
            checkOutput("data_0", 32'(data_0), 32'(e.d0));
            checkOutput("data_1", 32'(data_1), 32'(e.d1));
            checkOutput("dp", 32'(dp), 32'(e.dp));
            checkOutput("sw_chg", 32'(sw_chg), 32'(e.chg));
            if (e.gap != 0) checkOutput("gap", 32'(gap_cnt), 32'(e.gap));
          end
          gap_cnt = 0;
          prev    = cur;
        end
      end
    end
  end

  // Directed stimulus
  initial begin
    rst   = 1'b1;
    prswi = 8'h5A;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_prled", 32'(prled), 32'h00);
    checkOutput("rst_data_0", 32'(data_0), 32'd20);
    checkOutput("rst_data_1", 32'(data_1), 32'd20);
    checkOutput("rst_dp", 32'(dp), 32'd0);
    checkOutput("rst_sw_chg", 32'(sw_chg), 32'd0);
    #1;
    rst    = 1'b0;
    mon_en = 1'b1;

    // Single switch 2 ON: debounce, then S2 (revisits reload the same codes)
    pushExp(8'h04, 5'd20, 5'd20, 1'b0, 1'b1, 0);
    pushExp(8'h04, 5'd2, 5'd19, 1'b0, 1'b0, 0);
    applyStimulus(8'h04);
    waitDrain(40, "t2");
    idle(30);

    // Back to all off, then a short glitch that must be filtered
    pushExp(8'h00, 5'd2, 5'd19, 1'b0, 1'b1, 0);
    pushExp(8'h00, 5'd20, 5'd20, 1'b0, 1'b0, 1);
    applyStimulus(8'h00);
    waitDrain(40, "t3");
    idle(10);
    applyStimulus(8'h01);
    idle(3);
    applyStimulus(8'h00);
    idle(20);

    // Two switches: S0 (8 dwell + 2 seek), S2 (8 dwell + 6 seek wrap), S0, S2
    pushExp(8'h05, 5'd20, 5'd20, 1'b0, 1'b1, 0);
    pushExp(8'h05, 5'd20, 5'd20, 1'b1, 1'b0, 1);
    pushExp(8'h05, 5'd0, 5'd19, 1'b1, 1'b0, 1);
    pushExp(8'h05, 5'd2, 5'd19, 1'b1, 1'b0, 10);
    pushExp(8'h05, 5'd0, 5'd19, 1'b1, 1'b0, 14);
    pushExp(8'h05, 5'd2, 5'd19, 1'b1, 1'b0, 10);
    applyStimulus(8'h05);
    waitDrain(80, "t4");

    // All ON during SHOW, then all off
    pushExp(8'hFF, 5'd2, 5'd19, 1'b1, 1'b1, 0);
    pushExp(8'hFF, 5'd10, 5'd19, 1'b0, 1'b0, 1);
    applyStimulus(8'hFF);
    waitDrain(30, "t5a");
    pushExp(8'h00, 5'd10, 5'd19, 1'b0, 1'b1, 0);
    pushExp(8'h00, 5'd20, 5'd20, 1'b0, 1'b0, 1);
    applyStimulus(8'h00);
    waitDrain(30, "t5b");

    // Switches 0 and 7, reset mid-SHOW, then re-debounce to S0
    pushExp(8'h81, 5'd20, 5'd20, 1'b0, 1'b1, 0);
    pushExp(8'h81, 5'd20, 5'd20, 1'b1, 1'b0, 1);
    pushExp(8'h81, 5'd0, 5'd19, 1'b1, 1'b0, 1);
    applyStimulus(8'h81);
    waitDrain(30, "t6a");
    pushExp(8'h00, 5'd20, 5'd20, 1'b0, 1'b0, 0);
    pushExp(8'h81, 5'd20, 5'd20, 1'b0, 1'b1, 0);
    pushExp(8'h81, 5'd20, 5'd20, 1'b1, 1'b0, 1);
    pushExp(8'h81, 5'd0, 5'd19, 1'b1, 1'b0, 1);
    rst = 1'b1;
    @(negedge clk);
    #1;
    rst = 1'b0;
    waitDrain(40, "t6b");
    idle(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
